serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_chunk.sv | 31 +++
 rtl/serial_adder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count chunks 0..n-1 (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_chunk.sv
// Ripple chain of full_adder cells adding one BITS_PER_CYCLE-wide chunk per cycle.
module serial_adder_chunk #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] a,
    input  logic [BITS_PER_CYCLE-1:0] b,
    input  logic                      cin,
    output logic [BITS_PER_CYCLE-1:0] s,
    output logic                      cout,
    output logic                      c_top
);

    logic [BITS_PER_CYCLE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < int'(BITS_PER_CYCLE); i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c    (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // c_top is the carry into the chunk's top bit; for the last chunk that is the MSB.
    assign cout  = c[BITS_PER_CYCLE];
    assign c_top = c[BITS_PER_CYCLE-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle serial adder, BITS_PER_CYCLE bits per RUN cycle.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a + ~b + 1 when sub=1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned BPC_SAFE = (BITS_PER_CYCLE == 0) ? 1 : BITS_PER_CYCLE;
    localparam int unsigned N        = WIDTH / BPC_SAFE;
    localparam int unsigned CW       = cnt_width(N);

    if (WIDTH < 2 || BITS_PER_CYCLE == 0 || BITS_PER_CYCLE > WIDTH ||
        (WIDTH % BPC_SAFE) != 0) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          a_q, a_d;
    logic [WIDTH-1:0]          b_q, b_d;
    logic                      carry_q, carry_d;
    logic                      ctop_q, ctop_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]          psum_q, psum_d;
    logic [WIDTH-1:0]          sum_q, sum_d;
    logic                      cout_q, cout_d;
    logic                      ovf_q, ovf_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [BITS_PER_CYCLE-1:0] chunk_s;
    logic                      chunk_cout;
    logic                      chunk_ctop;
    logic [WIDTH-1:0]          psum_shift;

    serial_adder_chunk #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_chunk (
        .a     (a_q[BITS_PER_CYCLE-1:0]),
        .b     (b_q[BITS_PER_CYCLE-1:0]),
        .cin   (carry_q),
        .s     (chunk_s),
        .cout  (chunk_cout),
        .c_top (chunk_ctop)
    );

    // New chunk enters at the MSB so the finished word lands in place after N shifts.
    if (BITS_PER_CYCLE == WIDTH) begin : g_psum_full
        assign psum_shift = chunk_s;
    end else begin : g_psum_shift
        assign psum_shift = {chunk_s, psum_q[WIDTH-1:BITS_PER_CYCLE]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        ctop_d  = ctop_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    sum_d  = psum_q;
                    cout_d = carry_q;
                    ovf_d  = carry_q ^ ctop_q;
                    done_d = 1'b1;
                    state_d = IDLE;
                end
                if (start) begin
                    a_d     = a;
`ifdef SERIAL_ADDER_SUB_EN
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                carry_d = chunk_cout;
                ctop_d  = chunk_ctop;
                psum_d  = psum_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            ctop_q  <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            ctop_q  <= ctop_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
